data_ram: RTL



---
 rtl/data_ram.sv | 85 ++++++++
 1 files changed

// File: rtl/data_ram.sv
// Word-organised synchronous data memory for the OpenMIPS load/store path.
// Big-endian byte lanes, one access per cycle, one-cycle registered response.
module data_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Legal lane/offset pairs: aligned word, aligned halfword, any single byte.
  function automatic logic access_legal(input logic [3:0] lanes, input logic [1:0] offset);
    logic ok;
    case ({lanes, offset})
      6'b1111_00: ok = 1'b1;
      6'b1100_00: ok = 1'b1;
      6'b0011_10: ok = 1'b1;
      6'b1000_00: ok = 1'b1;
      6'b0100_01: ok = 1'b1;
      6'b0010_10: ok = 1'b1;
      6'b0001_11: ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [31:0]           mem_r [DEPTH] = '{default: 32'h0000_0000};
  logic [ADDR_WIDTH-1:0] index_s;
  logic                  legal_s;
  logic                  wr_en_s;

  // Decode the request; reset blocks any array write in the same cycle.
  always_comb begin
    index_s = addr[ADDR_WIDTH+1:2];
    legal_s = access_legal(sel, addr[1:0]);
    if (ce && we && legal_s && !reset) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Byte-lane store into the array.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en_s && sel[i]) begin
        mem_r[index_s][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  // Registered response: load data, ready and err strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= 32'h0000_0000;
      ready    <= 1'b0;
      err      <= 1'b0;
    end else if (ce) begin
      if (legal_s) begin
        ready <= 1'b1;
        err   <= 1'b0;
        if (!we) begin
          data_out <= mem_r[index_s];
        end
      end else begin
        data_out <= 32'h0000_0000;
        ready    <= 1'b0;
        err      <= 1'b1;
      end
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
    end
  end

endmodule
